// File: rtl/pio_input_shifter.sv
// pio_input_shifter: PIO input datapath; samples a rotated GPIO window into the ISR and pushes words to an RX FIFO.
// Ports:
//   clk, rst (async, active-low)
//   gpio_input, in_base, bit_count, shift_right     : IN window and shift control
//   autopush_en, push_thresh, in_req, push_req,
//   push_block                                      : request and push control
//   stall, isr_count                                : core-side status
//   rx_valid, rx_data, rx_pop, rx_level, rx_full    : host-side FIFO drain
//   rx_overflow, rx_overflow_clr                    : sticky drop flag, present only with PIO_RX_OVERFLOW_EN
module pio_input_shifter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] gpio_input,
  input  logic [4:0]        in_base,
  input  logic [5:0]        bit_count,
  input  logic              shift_right,
  input  logic              autopush_en,
  input  logic [5:0]        push_thresh,
  input  logic              in_req,
  input  logic              push_req,
  input  logic              push_block,
  output logic              stall,
  output logic [5:0]        isr_count,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_pop,
  output logic [3:0]        rx_level,
`ifdef PIO_RX_OVERFLOW_EN
  output logic              rx_overflow,
  input  logic              rx_overflow_clr,
`endif
  output logic              rx_full
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] isr, bits, shifted, wdata;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [2*DATA_W-1:0] dbl;
  logic [5:0] n, thresh, cnt_new;
  logic [6:0] cnt_sum;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_auto, wr_en, clr, pop;
  always_comb begin
    dbl = {gpio_input, gpio_input} >> in_base;
    n = (bit_count == 6'd0 || bit_count > 6'd32) ? 6'd32 : bit_count;
    bits = dbl[DATA_W-1:0] & ({DATA_W{1'b1}} >> (6'd32 - n));
    // shifting by the full width yields 0, so n=32 replaces the ISR in both directions
    shifted = shift_right ? (isr >> n) | (bits << (6'd32 - n)) : (isr << n) | bits;
    cnt_sum = {1'b0, isr_count} + {1'b0, n};
    cnt_new = cnt_sum > 7'd32 ? 6'd32 : cnt_sum[5:0];
    thresh = push_thresh == 6'd0 ? 6'd32 : push_thresh;
    do_auto = autopush_en && cnt_new >= thresh;
    // in_req takes priority; push_req only matters when no IN is requested
    stall = in_req ? do_auto & rx_full : push_req & rx_full & push_block;
    wr_en = in_req ? do_auto & ~rx_full : push_req & ~rx_full;
    clr = in_req ? do_auto & ~rx_full : push_req & ~(rx_full & push_block);
    wdata = in_req ? shifted : isr;
    pop = rx_pop & rx_valid;
    rx_valid = rx_level != 4'd0;
    rx_full = rx_level == 4'(FIFO_DEPTH);
    rx_data = mem[rd_ptr];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isr <= '0;
      isr_count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_level <= '0;
    end else begin
      if (clr) begin
        isr <= '0;
        isr_count <= '0;
      end else if (in_req && !stall) begin
        isr <= shifted;
        isr_count <= cnt_new;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      rx_level <= rx_level + {3'b0, wr_en} - {3'b0, pop};
    end
  end
  always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= wdata;
`ifdef PIO_RX_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_overflow <= 1'b0;
    else if (!in_req && push_req && rx_full && !push_block) rx_overflow <= 1'b1;
    else if (rx_overflow_clr) rx_overflow <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_pio_input_shifter.sv
// tb_pio_input_shifter: directed self-checking bench for pio_input_shifter.
module tb_pio_input_shifter;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] gpio_input = '0, rx_data;
  logic [4:0] in_base = '0;
  logic [5:0] bit_count = '0, push_thresh = '0, isr_count;
  logic shift_right = 0, autopush_en = 0, in_req = 0, push_req = 0, push_block = 0, rx_pop = 0;
  logic stall, rx_valid, rx_full;
  logic [3:0] rx_level;
`ifdef PIO_RX_OVERFLOW_EN
  logic rx_overflow, rx_overflow_clr = 0;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  pio_input_shifter #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .gpio_input(gpio_input), .in_base(in_base), .bit_count(bit_count),
    .shift_right(shift_right), .autopush_en(autopush_en), .push_thresh(push_thresh),
    .in_req(in_req), .push_req(push_req), .push_block(push_block), .stall(stall),
    .isr_count(isr_count), .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
    .rx_level(rx_level),
`ifdef PIO_RX_OVERFLOW_EN
    .rx_overflow(rx_overflow), .rx_overflow_clr(rx_overflow_clr),
`endif
    .rx_full(rx_full));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_in(input logic [31:0] g);
    gpio_input = g;
    in_req = 1;
    tick();
    in_req = 0;
  endtask
  task automatic do_push();
    push_req = 1;
    tick();
    push_req = 0;
  endtask
  task automatic do_pop();
    rx_pop = 1;
    tick();
    rx_pop = 0;
  endtask
  task automatic test_reset();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
    checks++; if (rx_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", rx_level); end
    checks++; if (isr_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", isr_count); end
    checks++; if (rx_full !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_full_stall got=%0b%0b exp=00", rx_full, stall); end
  endtask
  task automatic test_left_shift();
    in_base = 0; bit_count = 8; shift_right = 0;
    do_in(32'hA5);
    do_in(32'h3C);
    checks++; if (isr_count !== 6'd16) begin failures++; $display("FAIL left_count got=%0d exp=16", isr_count); end
    do_push();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h0000A53C) begin failures++; $display("FAIL left_data got=%h v=%0b exp=0000a53c", rx_data, rx_valid); end
    checks++; if (isr_count !== 6'd0 || rx_level !== 4'd1) begin failures++; $display("FAIL left_push_clear got cnt=%0d lvl=%0d exp 0/1", isr_count, rx_level); end
    do_pop();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL left_pop got=%0b exp=0", rx_valid); end
  endtask
  task automatic test_right_autopush();
    bit_count = 4; shift_right = 1; autopush_en = 1; push_thresh = 8;
    do_in(32'h1);
    checks++; if (isr_count !== 6'd4 || rx_valid !== 1'b0) begin failures++; $display("FAIL auto_first got cnt=%0d v=%0b exp 4/0", isr_count, rx_valid); end
    do_in(32'h2);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 32'h21000000) begin failures++; $display("FAIL auto_data got=%h v=%0b exp=21000000", rx_data, rx_valid); end
    checks++; if (isr_count !== 6'd0) begin failures++; $display("FAIL auto_count got=%0d exp=0", isr_count); end
    do_pop();
    autopush_en = 0;
  endtask
  task automatic test_window_wrap();
    in_base = 30; bit_count = 4; shift_right = 0;
    do_in(32'hC0000003);
    do_push();
    checks++; if (rx_data !== 32'h0000000F) begin failures++; $display("FAIL wrap_data got=%h exp=0000000f", rx_data); end
    do_pop();
    in_base = 0;
  endtask
  task automatic test_full_width();
    bit_count = 0; shift_right = 1;
    do_in(32'h12345678);
    checks++; if (isr_count !== 6'd32) begin failures++; $display("FAIL full_count got=%0d exp=32", isr_count); end
    do_in(32'h9ABCDEF0);
    checks++; if (isr_count !== 6'd32) begin failures++; $display("FAIL full_saturate got=%0d exp=32", isr_count); end
    do_push();
    checks++; if (rx_data !== 32'h9ABCDEF0) begin failures++; $display("FAIL full_replace got=%h exp=9abcdef0", rx_data); end
    do_pop();
    shift_right = 0;
  endtask
  task automatic test_simultaneous();
    bit_count = 8;
    gpio_input = 32'h77; in_req = 1; push_req = 1;
    tick();
    in_req = 0; push_req = 0;
    checks++; if (rx_level !== 4'd0 || isr_count !== 6'd8) begin failures++; $display("FAIL simul got lvl=%0d cnt=%0d exp 0/8", rx_level, isr_count); end
    do_push();
    do_in(32'h66);
    push_req = 1; rx_pop = 1;
    tick();
    push_req = 0; rx_pop = 0;
    checks++; if (rx_level !== 4'd1 || rx_data !== 32'h66) begin failures++; $display("FAIL push_pop got lvl=%0d data=%h exp 1/66", rx_level, rx_data); end
    do_pop();
  endtask
  task automatic test_fifo_block();
    bit_count = 8;
    for (int i = 1; i <= 4; i++) begin
      do_in(32'h11 * i);
      do_push();
    end
    checks++; if (rx_full !== 1'b1 || rx_level !== 4'd4) begin failures++; $display("FAIL fill got full=%0b lvl=%0d exp 1/4", rx_full, rx_level); end
    do_in(32'h55);
    push_block = 1; push_req = 1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL block_stall got=%0b exp=1", stall); end
    tick();
    checks++; if (isr_count !== 6'd8 || rx_level !== 4'd4) begin failures++; $display("FAIL block_hold got cnt=%0d lvl=%0d exp 8/4", isr_count, rx_level); end
    rx_pop = 1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL pop_no_unstall got=%0b exp=1", stall); end
    tick();
    rx_pop = 0;
    checks++; if (rx_level !== 4'd3 || stall !== 1'b0) begin failures++; $display("FAIL after_pop got lvl=%0d stall=%0b exp 3/0", rx_level, stall); end
    tick();
    push_req = 0; push_block = 0;
    checks++; if (rx_level !== 4'd4 || isr_count !== 6'd0) begin failures++; $display("FAIL held_push got lvl=%0d cnt=%0d exp 4/0", rx_level, isr_count); end
    autopush_en = 1; push_thresh = 8; gpio_input = 32'h99; in_req = 1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL auto_full_stall got=%0b exp=1", stall); end
    tick();
    in_req = 0; autopush_en = 0;
    checks++; if (isr_count !== 6'd0 || rx_level !== 4'd4) begin failures++; $display("FAIL auto_full_hold got cnt=%0d lvl=%0d exp 0/4", isr_count, rx_level); end
  endtask
  task automatic test_drop();
    logic [31:0] exp_words [4];
    exp_words = '{32'h22, 32'h33, 32'h44, 32'h55};
    bit_count = 0;
    do_in(32'hDEADBEEF);
    push_block = 0; push_req = 1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL drop_stall got=%0b exp=0", stall); end
    tick();
    push_req = 0;
    checks++; if (isr_count !== 6'd0 || rx_level !== 4'd4) begin failures++; $display("FAIL drop_state got cnt=%0d lvl=%0d exp 0/4", isr_count, rx_level); end
`ifdef PIO_RX_OVERFLOW_EN
    tick();
    checks++; if (rx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", rx_overflow); end
    rx_overflow_clr = 1;
    tick();
    rx_overflow_clr = 0;
    checks++; if (rx_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", rx_overflow); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_words[i]) begin failures++; $display("FAIL drain%0d got=%h v=%0b exp=%h", i, rx_data, rx_valid, exp_words[i]); end
      do_pop();
    end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", rx_valid); end
  endtask
  task automatic test_async_reset();
    bit_count = 8;
    do_in(32'h01); do_push();
    do_in(32'h02); do_push();
    bit_count = 12;
    do_in(32'hABC);
    checks++; if (rx_level !== 4'd2 || isr_count !== 6'd12) begin failures++; $display("FAIL pre_reset got lvl=%0d cnt=%0d exp 2/12", rx_level, isr_count); end
    #2 rst = 0;
    #1;
    checks++; if (rx_level !== 4'd0 || isr_count !== 6'd0 || rx_valid !== 1'b0 || rx_full !== 1'b0) begin failures++; $display("FAIL async_reset got lvl=%0d cnt=%0d v=%0b exp 0/0/0", rx_level, isr_count, rx_valid); end
    tick();
    rst = 1;
    do_pop();
    checks++; if (rx_level !== 4'd0 || rx_valid !== 1'b0) begin failures++; $display("FAIL pop_after_reset got lvl=%0d v=%0b exp 0/0", rx_level, rx_valid); end
  endtask
  initial begin
    tick();
    tick();
    test_reset();
    rst = 1;
    tick();
    test_left_shift();
    test_right_autopush();
    test_window_wrap();
    test_full_width();
    test_simultaneous();
    test_fifo_block();
    test_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pio_input_shifter.md
Name: pio_input_shifter

Overview:
- Input-direction datapath for one PIO state machine; the counterpart of the output path that drives the GPIO bank.
- Samples the synchronized GPIO input bus, gathers bits in an input shift register (ISR), and pushes completed words into an RX FIFO.
- The FIFO is drained by the host/bus side through a valid/pop handshake.
- One instance per state machine, inside each pio_core; the bus arrives from the gpio bank's in_data.

Parameters:
- FIFO_DEPTH, 4, RX FIFO entries; power of two, 2..8.
- DATA_W, 32, ISR/FIFO word width and GPIO bus width.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- gpio_input  input  32  synchronized pin levels.
- in_base  input  5  first pin of the IN window.
- bit_count  input  6  bits to shift per IN; 1..32, 0 treated as 32.
- shift_right  input  1  1 = shift ISR right (new bits enter at MSB), 0 = left (new bits enter at LSB).
- autopush_en  input  1  enable automatic push at threshold.
- push_thresh  input  6  autopush threshold; 0 treated as 32.
- in_req  input  1  perform one IN this cycle.
- push_req  input  1  explicit PUSH this cycle.
- push_block  input  1  PUSH blocks while FIFO full.
- stall  output  1  request not taken; core must hold its request.
- isr_count  output  6  valid bits in ISR, 0..32.
- rx_valid  output  1  FIFO not empty.
- rx_data  output  32  FIFO head word.
- rx_pop  input  1  consume head; ignored when rx_valid=0.
- rx_level  output  4  FIFO occupancy.
- rx_full  output  1  occupancy == FIFO_DEPTH.

Behaviour:
- Reset (rst=0, async): ISR=0, isr_count=0, FIFO empty, rx_valid=0, rx_level=0, rx_full=0, stall=0; FIFO contents are don't-care.
- Window: sample = gpio_input rotated right by in_base; use the low n bits, where n = effective bit_count.
- IN, left shift: ISR <= (ISR << n) | sample[n-1:0].
- IN, right shift: ISR <= (ISR >> n) | (sample[n-1:0] << (32-n)); n=32 replaces the ISR entirely.
- Count after IN: isr_count <= min(isr_count+n, 32); saturates and never wraps.
- Autopush:
  - Triggers when autopush_en=1 and the post-shift count >= threshold.
  - The shifted ISR value is written to the FIFO in the same cycle; ISR and count clear to 0.
  - If rx_full at cycle start, the IN is not performed, stall=1, and ISR is unchanged.
- Explicit PUSH (push_req=1, in_req=0):
  - Not full: push the current ISR, clear ISR and count.
  - Full with push_block=1: stall=1, no state change.
  - Full with push_block=0: word dropped, ISR and count cleared, stall=0.
- Simultaneous in_req and push_req: in_req wins, push_req is ignored that cycle, stall reflects the IN only.
- stall is combinational from cycle-start state and the requests; it is 0 when no request is active.
- rx_full is evaluated at cycle start. A pop in the same cycle does not un-stall a push; the push succeeds the next cycle.
- FIFO:
  - Synchronous write; a pushed word appears at rx_data with rx_valid=1 on the next cycle (latency 1).
  - Pop advances the head next cycle.
  - Push and pop in the same non-full, non-empty cycle leave rx_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data is held stable while rx_valid=1 and there is no pop.

Optional Feature:
- Macro: PIO_RX_OVERFLOW_EN.
- Defined:
  - Adds output rx_overflow (1b, sticky) and input rx_overflow_clr (1b).
  - rx_overflow sets on any dropped non-blocking PUSH.
  - It clears on rx_overflow_clr=1; set wins over clear in the same cycle.
  - Reset value is 0.
- Undefined: the ports are absent and dropped words leave no trace; all other behaviour is identical.

Test Plan:
- Reset, then left shift: in_base=0, bit_count=8, shift_right=0, gpio_input=0x000000A5, two IN requests with the second input 0x3C -> ISR=0x0000A53C, isr_count=16.
- Right shift autopush: bit_count=4, shift_right=1, autopush_en=1, push_thresh=8, inputs 0x1 then 0x2 -> the second IN pushes 0x21000000; rx_valid=1 the next cycle; isr_count=0.
- Window wrap: in_base=30, bit_count=4, gpio_input=0xC0000003 -> sample low bits=0xF; left shift from 0 gives ISR=0xF.
- Fill the FIFO (DEPTH=4) with explicit pushes, then push_block=1 PUSH -> stall=1 and ISR unchanged. Pop once -> the held PUSH succeeds the next cycle and rx_level returns to 4.
- FIFO full, push_block=0 PUSH of 0xDEADBEEF -> stall=0, ISR cleared, rx_level stays 4, and draining yields the original 4 words. With PIO_RX_OVERFLOW_EN, rx_overflow=1 until rx_overflow_clr.
- Assert rst=0 mid-operation with FIFO level 2 and isr_count=12 -> all outputs are immediately 0, and the first pop after release is ignored (rx_valid=0).
